// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling from a single bit-timing counter,
// registered data/rcv/ferr outputs and a WAIT_HIGH state that absorbs break conditions.
module uart_rx #(
  parameter int unsigned BAUDRATE = 1250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rcv,
  output logic       ferr,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(BAUDRATE);
  localparam logic [CntW-1:0] CntLast = CntW'(BAUDRATE - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(BAUDRATE / 2 - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        data_q, data_d;
  logic              rcv_q, rcv_d;
  logic              ferr_q, ferr_d;
  logic              rx_meta_q, rx_s_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      rcv_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      rcv_q     <= rcv_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    rcv_d   = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = StStart;
          idx_d   = '0;
        end
      end
      StStart: begin
        // Re-phase the counter at mid start bit so every later sample lands on cnt == CntLast.
        if (cnt_q == CntHalf) begin
          cnt_d   = '0;
          state_d = rx_s_q ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == CntLast) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = StStop;
          end
        end
      end
      StStop: begin
        if (cnt_q == CntLast) begin
          if (rx_s_q) begin
            data_d  = shift_q;
            rcv_d   = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StWaitHigh;
          end
        end
      end
      StWaitHigh: begin
        if (rx_s_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign data = data_q;
  assign rcv  = rcv_q;
  assign ferr = ferr_q;
  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a BAUDRATE=16 instance driven through frames, glitches, breaks,
// back-to-back traffic and mid-frame reset, plus a default-rate instance for one frame.
module tb_uart_rx;

  localparam int unsigned B  = 16;
  localparam int unsigned BD = 1250;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_def = 1'b1;
  logic [7:0] data, data_def;
  logic       rcv, ferr, busy;
  logic       rcv_def, ferr_def, busy_def;

  uart_rx #(.BAUDRATE(B)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .data (data),
    .rcv  (rcv),
    .ferr (ferr),
    .busy (busy)
  );

  uart_rx u_dut_def (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx_def),
    .data (data_def),
    .rcv  (rcv_def),
    .ferr (ferr_def),
    .busy (busy_def)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] d;
    int         at;
  } exp_t;
  exp_t sb[$];

  int rcv_cnt = 0, ferr_cnt = 0, last_rcv_at = 0, prev_rcv_at = 0, last_ferr_at = 0;
  int busy_rise = 0, busy_fall = 0;
  logic busy_prev = 1'b0;
  int def_rcv_cnt = 0, def_ferr_cnt = 0, def_rcv_at = 0;
  logic [7:0] def_data_at = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sampled mid-cycle; "at" values name the next rising edge, the first one that sees the value.
  always @(negedge clk) begin
    exp_t e;
    if (rcv || ferr) check("rcv_ferr_exclusive", 32'(rcv & ferr), 32'd0);
    if (rcv) begin
      rcv_cnt++;
      prev_rcv_at = last_rcv_at;
      last_rcv_at = cyc + 1;
      check("sb_nonempty_at_rcv", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("rcv_data", 32'(data), 32'(e.d));
        check("rcv_cycle", 32'(cyc + 1), 32'(e.at));
      end
    end
    if (ferr) begin
      ferr_cnt++;
      last_ferr_at = cyc + 1;
    end
    if (busy && !busy_prev) busy_rise = cyc + 1;
    if (!busy && busy_prev) busy_fall = cyc + 1;
    busy_prev = busy;
    if (rcv_def) begin
      def_rcv_cnt++;
      def_rcv_at = cyc + 1;
      def_data_at = data_def;
    end
    if (ferr_def) def_ferr_cnt++;
  end

  task automatic wait_clk(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit def_line, input logic v);
    if (def_line) rx_def = v;
    else rx = v;
  endtask

  task automatic send_frame(input int period, input bit def_line, input logic [7:0] b,
                            input logic stop_bit);
    drive(def_line, 1'b0);
    wait_clk(period);
    for (int i = 0; i < 8; i++) begin
      drive(def_line, b[i]);
      wait_clk(period);
    end
    drive(def_line, stop_bit);
    wait_clk(period);
  endtask

  // Start edge driven at cyc n is sampled at edge n+1, so t0 = n+3.
  task automatic send_good(input logic [7:0] b);
    exp_t e;
    e.d  = b;
    e.at = cyc + 3 + int'(B / 2) + 9 * int'(B) + 1;
    sb.push_back(e);
    send_frame(B, 1'b0, b, 1'b1);
  endtask

  initial begin
    int n, m;
    wait_clk(4);
    check("reset_data", 32'(data), 32'h00);
    check("reset_rcv", 32'(rcv), 32'd0);
    check("reset_ferr", 32'(ferr), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_data_def", 32'(data_def), 32'h00);
    rst = 1'b0;
    wait_clk(5);

    // Single good frame
    n = cyc;
    send_good(8'hA5);
    wait_clk(20);
    check("a5_rcv_count", 32'(rcv_cnt), 32'd1);
    check("a5_data", 32'(data), 32'hA5);
    check("a5_no_ferr", 32'(ferr_cnt), 32'd0);
    check("a5_busy_rise", 32'(busy_rise), 32'(n + 4));
    check("a5_busy_fall", 32'(busy_fall), 32'(n + 156));

    // 3-cycle low glitch is a false start
    n = cyc;
    rx = 1'b0;
    wait_clk(3);
    rx = 1'b1;
    wait_clk(30);
    check("glitch_busy_rise", 32'(busy_rise), 32'(n + 4));
    check("glitch_busy_fall", 32'(busy_fall), 32'(n + 12));
    check("glitch_rcv_count", 32'(rcv_cnt), 32'd1);
    check("glitch_ferr_count", 32'(ferr_cnt), 32'd0);
    check("glitch_data", 32'(data), 32'hA5);

    // Framing error followed by a break
    n = cyc;
    send_frame(B, 1'b0, 8'h3C, 1'b0);
    wait_clk(40);
    check("break_busy_held", 32'(busy), 32'd1);
    m = cyc;
    rx = 1'b1;
    wait_clk(10);
    check("ferr_count", 32'(ferr_cnt), 32'd1);
    check("ferr_cycle", 32'(last_ferr_at), 32'(n + 156));
    check("ferr_busy_fall", 32'(busy_fall), 32'(m + 4));
    check("ferr_rcv_count", 32'(rcv_cnt), 32'd1);
    check("ferr_data_kept", 32'(data), 32'hA5);

    // Back-to-back frames with no idle gap
    wait_clk(5);
    send_good(8'h00);
    send_good(8'hFF);
    wait_clk(20);
    check("b2b_rcv_count", 32'(rcv_cnt), 32'd3);
    check("b2b_spacing", 32'(last_rcv_at - prev_rcv_at), 32'd160);
    check("b2b_data", 32'(data), 32'hFF);

    // Reset in the middle of data bit 4
    rx = 1'b0;
    wait_clk(int'(B) + 4 * int'(B) + int'(B / 2));
    rst = 1'b1;
    rx = 1'b1;
    wait_clk(3);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_data", 32'(data), 32'h00);
    rst = 1'b0;
    wait_clk(200);
    check("midrst_rcv_count", 32'(rcv_cnt), 32'd3);
    check("midrst_ferr_count", 32'(ferr_cnt), 32'd1);
    check("midrst_busy_idle", 32'(busy), 32'd0);
    send_good(8'h81);
    wait_clk(20);
    check("after_rst_rcv_count", 32'(rcv_cnt), 32'd4);
    check("after_rst_data", 32'(data), 32'h81);

    // Default BAUDRATE instance
    n = cyc;
    send_frame(BD, 1'b1, 8'h55, 1'b1);
    wait_clk(20);
    check("def_rcv_count", 32'(def_rcv_cnt), 32'd1);
    check("def_rcv_cycle", 32'(def_rcv_at), 32'(n + 3 + 625 + 11250 + 1));
    check("def_data_at_rcv", 32'(def_data_at), 32'h55);
    check("def_data", 32'(data_def), 32'h55);
    check("def_ferr_count", 32'(def_ferr_cnt), 32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BAUDRATE, default 1250, meaning the bit period in clk cycles (12 MHz / 9600 baud); legal range is 4 or more.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all logic is on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port rx, input, 1 bit: serial line, asynchronous to clk, idle high, 8N1 framing, LSB first.
REQ-005 SHALL have port data, output, 8 bits: the last correctly framed byte, registered.
REQ-006 SHALL have port rcv, output, 1 bit: one-cycle pulse, high when data has just been updated.
REQ-007 SHALL have port ferr, output, 1 bit: one-cycle pulse flagging a framing error (stop bit sampled 0).
REQ-008 SHALL have port busy, output, 1 bit: high while a frame is in progress (any state other than IDLE).

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer (rx_s); all decisions use rx_s only; the synchronizer resets to 1.
REQ-010 SHALL contain one bit-timing counter of width clog2(BAUDRATE), counting 0..BAUDRATE-1 and wrapping to 0; the counter advances only outside IDLE.
REQ-011 SHALL implement a state machine with states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-012 IDLE: leave for START in the first cycle t0 where rx_s = 0, and clear the counter and bit index.
REQ-013 START: sample rx_s at t0 + BAUDRATE/2 (integer division); sample 0 -> DATA; sample 1 -> IDLE (false start: no rcv, no ferr).
REQ-014 DATA: sample bit i (i = 0..7) at t0 + BAUDRATE/2 + (i+1)*BAUDRATE into a shift register LSB first; after bit 7 -> STOP.
REQ-015 STOP: sample at t0 + BAUDRATE/2 + 9*BAUDRATE.
REQ-016 STOP sample = 1: in the next cycle, load data from the shift register, pulse rcv for exactly 1 cycle, and go to IDLE.
REQ-017 STOP sample = 0: in the next cycle, pulse ferr for exactly 1 cycle, leave data unchanged, and go to WAIT_HIGH.
REQ-018 WAIT_HIGH: stay until rx_s = 1, then go to IDLE, so a break condition yields exactly one ferr and no spurious frames.
REQ-019 rcv and ferr SHALL never be high in the same cycle, and neither SHALL be high outside the post-STOP cycle.
REQ-020 A new start bit that is low in the same cycle the FSM re-enters IDLE SHALL be detected in the following cycle, so back-to-back frames are received with no lost byte.
REQ-021 data SHALL hold its value between rcv pulses; the shift register contents are not visible on data.
REQ-022 Total latency SHALL be: rcv high at cycle t0 + BAUDRATE/2 + 9*BAUDRATE + 1, where t0 = (first clk edge sampling the rx pin low) + 2.

Reset
REQ-023 While rst = 1 SHALL force: state IDLE, counter 0, bit index 0, shift register 0x00, data 0x00, rcv 0, ferr 0, busy 0, synchronizer flops 1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no rcv and no ferr; after release, the FSM waits in IDLE for a fresh falling edge of rx_s.
REQ-025 If rx is low when rst releases, the block SHALL treat it as a start edge after the synchronizer delay (IDLE rule applies unchanged).

Verification
REQ-026 BAUDRATE=16, send 0xA5 with a valid stop bit -> one rcv pulse at t0+8+144+1, data=0xA5, ferr never high, busy high from t0+1 until the rcv cycle.
REQ-027 BAUDRATE=16, rx low glitch of 3 cycles -> busy pulses, then IDLE; rcv=0, ferr=0, data unchanged.
REQ-028 BAUDRATE=16, send 0x3C with stop=0, then rx held low for 40 cycles, then high -> exactly one ferr pulse, data still the previous value, no rcv, busy low only after rx_s returns high.
REQ-029 BAUDRATE=16, frames 0x00 then 0xFF back-to-back with no idle gap -> two rcv pulses exactly 160 cycles apart, data 0x00 then 0xFF.
REQ-030 BAUDRATE=16, rst pulse during bit 4 of a frame, then send 0x81 -> no output for the aborted frame, data=0x81 with one rcv.
REQ-031 Default BAUDRATE=1250, send 0x55 -> rcv at t0+625+11250+1, data=0x55.
